// File: rtl/multicycle_control_unit.sv
// Main controller for the multicycle MIPS core. It steps each instruction through
// fetch/decode/execute/memory/writeback and decodes the datapath controls from the state register.
module multicycle_control_unit #(
    parameter int WORD_LENGTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    if (WORD_LENGTH < 6) begin : g_width_check
        $error("WORD_LENGTH must hold at least the opcode field");
    end

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    state_t  state_q;
    state_t  state_d;
    alu_op_t alu_op;
    logic    pc_write;
    logic    branch;
    logic    ir_write;
    logic    mem_write;
    logic    reg_write;
    logic    opcode_ok;
    logic    funct_ok;
    logic [2:0] funct_ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        opcode_ok = 1'b1;
        case (Opcode)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: opcode_ok = 1'b1;
            default:                                       opcode_ok = 1'b0;
        endcase
    end

    always_comb begin
        funct_ctrl = 3'b010;
        funct_ok   = 1'b1;
        case (Funct)
            6'h20:   funct_ctrl = 3'b010;
            6'h22:   funct_ctrl = 3'b110;
            6'h24:   funct_ctrl = 3'b000;
            6'h25:   funct_ctrl = 3'b001;
            6'h2A:   funct_ctrl = 3'b111;
            default: funct_ok   = 1'b0;
        endcase
    end

    // Next state; the unused codes 12-15 fall back to FETCH through the default.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write  = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        IorD      = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        alu_op    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                ALUSrcB  = 2'b01;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: IorD = 1'b1;
            S_MEMWB: begin
                reg_write = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_MEMWRITE: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                RegDst    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALU_SUB;
                branch  = 1'b1;
                PCSrc   = 2'b01;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write = 1'b1;
                PCSrc    = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SUB:   ALUControl = 3'b110;
            ALU_FUNCT: ALUControl = funct_ctrl;
            default:   ALUControl = 3'b010;
        endcase
    end

    // Reset holds the state at FETCH, so only the enables need masking here.
    assign IRWrite  = ir_write & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign PCEn     = ~reset & (pc_write | (branch & Zero));
    assign Illegal  = ~reset & (((state_q == S_DECODE) & ~opcode_ok) |
                                ((state_q == S_EXECUTE) & ~funct_ok));
    assign State    = state_q;

endmodule
